// File: rtl/capture_pkg.sv
// Shared constants and types for the capture-path packet arbiter.
package capture_pkg;

    localparam int         C_CNT_WIDTH_DEF = 32;
    localparam logic [3:0] WEIGHT_0_DEF    = 4'd1;
    localparam logic [3:0] WEIGHT_1_DEF    = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } arb_state_e;

    // A programmed weight of zero still allows one packet per round.
    function automatic logic [4:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 5'd1 : {1'b0, w};
    endfunction

endpackage

// File: rtl/capture_wrr_credit.sv
// Weighted round-robin preference and credit tracking, updated once per forwarded packet.
module capture_wrr_credit
    import capture_pkg::*;
(
    input  logic       axi_aclk,
    input  logic       axi_areset,
    input  logic       tlast_done_i,
    input  logic       port_i,
    input  logic [3:0] weight_0_i,
    input  logic [3:0] weight_1_i,
    input  logic       drop_mode_i,
    output logic       pref_o
);

    logic       pref_q, pref_d;
    logic [3:0] cred_q, cred_d;
    logic [4:0] cred_inc;
    logic [4:0] weight_eff;

    always_comb begin
        pref_d     = pref_q;
        cred_d     = cred_q;
        cred_inc   = {1'b0, cred_q} + 5'd1;
        weight_eff = port_i ? eff_weight(weight_1_i) : eff_weight(weight_0_i);
        if (tlast_done_i) begin
            if (drop_mode_i) begin
                // With capture off only input 0 is forwarded; keep the round anchored on it.
                if (!port_i) begin
                    pref_d = 1'b0;
                    cred_d = 4'd0;
                end
            end else if (port_i == pref_q) begin
                if (cred_inc >= weight_eff) begin
                    pref_d = ~pref_q;
                    cred_d = 4'd0;
                end else begin
                    cred_d = cred_inc[3:0];
                end
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            pref_q <= 1'b0;
            cred_q <= 4'd0;
        end else begin
            pref_q <= pref_d;
            cred_q <= cred_d;
        end
    end

    assign pref_o = pref_q;

endmodule

// File: rtl/capture_pkt_arbiter.sv
// Packet-granular WRR merge of the forwarded (0) and capture (1) streams onto one AXI4-Stream.
//   state | meaning
//   IDLE  | no grant; arbitrate between requesting inputs this cycle
//   PKT0  | input 0 owns the output until its tlast beat transfers
//   PKT1  | input 1 owns the output until its tlast beat transfers
module capture_pkt_arbiter
    import capture_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = C_CNT_WIDTH_DEF
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                            s_axis_tlast_0,
    input  logic                            s_axis_tvalid_0,
    output logic                            s_axis_tready_0,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                            s_axis_tlast_1,
    input  logic                            s_axis_tvalid_1,
    output logic                            s_axis_tready_1,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic [3:0]                      cfg_weight_0,
    input  logic [3:0]                      cfg_weight_1,
    input  logic                            cfg_capture_en,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt_0,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt_1,
    output logic [C_CNT_WIDTH-1:0]          drop_cnt_1
);

    arb_state_e             state_q, state_d;
    logic                   drop_mode_q;
    logic                   s1_mid_q, s1_mid_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_0_q, pkt_cnt_1_q, drop_cnt_1_q;
    logic                   pref;
    logic                   fire_0, fire_1;
    logic                   done_0, fwd_done_1, drop_done_1;
    logic                   req_0, req_1;

    always_comb begin
        m_axis_tdata    = '0;
        m_axis_tstrb    = '0;
        m_axis_tuser    = '0;
        m_axis_tlast    = 1'b0;
        m_axis_tvalid   = 1'b0;
        s_axis_tready_0 = 1'b0;
        s_axis_tready_1 = 1'b0;
        if (!axi_areset) begin
            case (state_q)
                PKT0: begin
                    m_axis_tdata    = s_axis_tdata_0;
                    m_axis_tstrb    = s_axis_tstrb_0;
                    m_axis_tuser    = s_axis_tuser_0;
                    m_axis_tlast    = s_axis_tlast_0;
                    m_axis_tvalid   = s_axis_tvalid_0;
                    s_axis_tready_0 = m_axis_tready;
                end
                PKT1: begin
                    m_axis_tdata    = s_axis_tdata_1;
                    m_axis_tstrb    = s_axis_tstrb_1;
                    m_axis_tuser    = s_axis_tuser_1;
                    m_axis_tlast    = s_axis_tlast_1;
                    m_axis_tvalid   = s_axis_tvalid_1;
                    s_axis_tready_1 = m_axis_tready;
                end
                default: ;
            endcase
            if (drop_mode_q && state_q != PKT1) s_axis_tready_1 = 1'b1;
        end
    end

    assign fire_0      = s_axis_tvalid_0 & s_axis_tready_0;
    assign fire_1      = s_axis_tvalid_1 & s_axis_tready_1;
    assign done_0      = fire_0 & s_axis_tlast_0;
    assign fwd_done_1  = fire_1 & s_axis_tlast_1 & (state_q == PKT1);
    assign drop_done_1 = fire_1 & s_axis_tlast_1 & (state_q != PKT1);
    assign req_0       = s_axis_tvalid_0;
    assign req_1       = s_axis_tvalid_1 & ~drop_mode_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pref ? req_1 : req_0)      state_d = pref ? PKT1 : PKT0;
                else if (pref ? req_0 : req_1) state_d = pref ? PKT0 : PKT1;
            end
            PKT0:    if (done_0)     state_d = IDLE;
            PKT1:    if (fwd_done_1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        s1_mid_d = s1_mid_q;
        if (fire_1) s1_mid_d = ~s1_mid_tlast(s_axis_tlast_1);
    end

    function automatic logic s1_mid_tlast(input logic last);
        return last;
    endfunction

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= IDLE;
            drop_mode_q  <= 1'b0;
            s1_mid_q     <= 1'b0;
            pkt_cnt_0_q  <= '0;
            pkt_cnt_1_q  <= '0;
            drop_cnt_1_q <= '0;
        end else begin
            state_q  <= state_d;
            s1_mid_q <= s1_mid_d;
            // Mode only moves when input 1 sits between packets and is not being granted,
            // so neither a first beat nor a fresh grant can split a packet across modes.
            if (!s1_mid_d && state_d != PKT1) drop_mode_q <= ~cfg_capture_en;
            if (done_0)      pkt_cnt_0_q  <= pkt_cnt_0_q + C_CNT_WIDTH'(1);
            if (fwd_done_1)  pkt_cnt_1_q  <= pkt_cnt_1_q + C_CNT_WIDTH'(1);
            if (drop_done_1) drop_cnt_1_q <= drop_cnt_1_q + C_CNT_WIDTH'(1);
        end
    end

    capture_wrr_credit u_credit (
        .axi_aclk     (axi_aclk),
        .axi_areset   (axi_areset),
        .tlast_done_i (done_0 | fwd_done_1),
        .port_i       (state_q == PKT1),
        .weight_0_i   (cfg_weight_0),
        .weight_1_i   (cfg_weight_1),
        .drop_mode_i  (drop_mode_q),
        .pref_o       (pref)
    );

    assign pkt_cnt_0  = pkt_cnt_0_q;
    assign pkt_cnt_1  = pkt_cnt_1_q;
    assign drop_cnt_1 = drop_cnt_1_q;

endmodule

// File: tb/tb_capture_pkt_arbiter.sv
// Scoreboard bench for capture_pkt_arbiter: directed packets in, expected beat order queued, monitor compares.
module tb_capture_pkt_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int CW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata_0, s_tdata_1, m_tdata;
    logic [SW-1:0] s_tstrb_0, s_tstrb_1, m_tstrb;
    logic [UW-1:0] s_tuser_0, s_tuser_1, m_tuser;
    logic          s_tlast_0, s_tlast_1, m_tlast;
    logic          s_tvalid_0 = 1'b0, s_tvalid_1 = 1'b0, m_tvalid;
    logic          s_tready_0, s_tready_1;
    logic          m_tready = 1'b1;
    logic [3:0]    w0 = 4'd1, w1 = 4'd1;
    logic          cap_en = 1'b1;
    logic [CW-1:0] pkt_cnt_0, pkt_cnt_1, drop_cnt_1;

    beat_t q0[$], q1[$], exp_q[$];
    int    checks = 0, errors = 0;
    int    fire0_cnt = 0, fire1_cnt = 0;
    int    cyc = 0, first_fire_cyc = -1, last_fire_cyc = -1;
    bit    stall_en = 1'b0, watch_t1 = 1'b0, t1_hi_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    capture_pkt_arbiter dut (
        .axi_aclk(clk), .axi_areset(rst),
        .s_axis_tdata_0(s_tdata_0), .s_axis_tstrb_0(s_tstrb_0), .s_axis_tuser_0(s_tuser_0),
        .s_axis_tlast_0(s_tlast_0), .s_axis_tvalid_0(s_tvalid_0), .s_axis_tready_0(s_tready_0),
        .s_axis_tdata_1(s_tdata_1), .s_axis_tstrb_1(s_tstrb_1), .s_axis_tuser_1(s_tuser_1),
        .s_axis_tlast_1(s_tlast_1), .s_axis_tvalid_1(s_tvalid_1), .s_axis_tready_1(s_tready_1),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .cfg_weight_0(w0), .cfg_weight_1(w1), .cfg_capture_en(cap_en),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .drop_cnt_1(drop_cnt_1)
    );

    function automatic beat_t mk_beat(input int port, input int pkt, input int idx, input bit last);
        beat_t      b;
        logic [31:0] w;
        logic [7:0]  p8, k8, i8;
        p8 = port[7:0];
        k8 = pkt[7:0];
        i8 = idx[7:0];
        w  = {p8, k8, i8, 8'hA5};
        b.data = {8{w}};
        b.user = {4{~w}};
        b.strb = w ^ 32'h0F0F_3C3C;
        b.last = last;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_pkt(input int port, input int pkt, input int n);
        for (int i = 0; i < n; i++) begin
            if (port == 0) q0.push_back(mk_beat(0, pkt, i, i == n - 1));
            else           q1.push_back(mk_beat(1, pkt, i, i == n - 1));
        end
    endtask

    task automatic expect_pkt(input int port, input int pkt, input int n, input int upto);
        for (int i = 0; i < upto; i++) exp_q.push_back(mk_beat(port, pkt, i, i == n - 1));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) break;
            step(1);
        end
        if (i >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, q0=%0d q1=%0d exp=%0d", name, q0.size(), q1.size(), exp_q.size());
        end
        step(3);
    endtask

    task automatic wait_fire(input int port, input int target, input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (((port == 0) ? fire0_cnt : fire1_cnt) >= target) break;
            step(1);
        end
        if (i >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for input %0d beat count %0d", name, port, target);
        end
    endtask

    // source driver, input 0
    initial begin
        bit f;
        forever begin
            @(negedge clk);
            f = s_tvalid_0 && s_tready_0;
            if (f) fire0_cnt++;
            @(posedge clk);
            #2;
            if (f && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s_tdata_0 = q0[0].data; s_tuser_0 = q0[0].user;
                s_tstrb_0 = q0[0].strb; s_tlast_0 = q0[0].last;
                s_tvalid_0 = 1'b1;
            end else begin
                s_tvalid_0 = 1'b0;
            end
        end
    end

    // source driver, input 1
    initial begin
        bit f;
        forever begin
            @(negedge clk);
            f = s_tvalid_1 && s_tready_1;
            if (f) fire1_cnt++;
            @(posedge clk);
            #2;
            if (f && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                s_tdata_1 = q1[0].data; s_tuser_1 = q1[0].user;
                s_tstrb_1 = q1[0].strb; s_tlast_1 = q1[0].last;
                s_tvalid_1 = 1'b1;
            end else begin
                s_tvalid_1 = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // output monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (watch_t1 && s_tready_1) t1_hi_seen = 1'b1;
            if (m_tvalid && m_tready) begin
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                last_fire_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: unexpected beat data=%h last=%b", m_tdata[31:0], m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tuser !== e.user || m_tstrb !== e.strb || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h user=%h strb=%h last=%b expected data=%h user=%h strb=%h last=%b",
                                 m_tdata[31:0], m_tuser[31:0], m_tstrb, m_tlast,
                                 e.data[31:0], e.user[31:0], e.strb, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int base0, base1, k;

        // reset state
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_tready_0", s_tready_0, 0);
        chk("rst_tready_1", s_tready_1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_tdata_zero", m_tdata == '0, 1);
        chk("rst_cnt_0", pkt_cnt_0, 0);
        chk("rst_drop_cnt", drop_cnt_1, 0);
        step(1);

        // weights 1/1: strict alternation, 4-beat packets with one bubble between
        w0 = 4'd1; w1 = 4'd1;
        first_fire_cyc = -1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(0, p, 4);
            send_pkt(1, p, 4);
            expect_pkt(0, p, 4, 4);
            expect_pkt(1, p, 4, 4);
        end
        wait_drain("alt_1_1", 400);
        chk("alt_cnt_0", pkt_cnt_0, 4);
        chk("alt_cnt_1", pkt_cnt_1, 4);
        chk("alt_span_cycles", last_fire_cyc - first_fire_cyc, 38);

        // weights 3/1: 0,0,0,1 repeated
        do_reset();
        w0 = 4'd3; w1 = 4'd1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                send_pkt(0, 3 * r + j, 2);
                expect_pkt(0, 3 * r + j, 2, 2);
            end
            send_pkt(1, r, 2);
            expect_pkt(1, r, 2, 2);
        end
        wait_drain("wrr_3_1", 500);
        chk("wrr_cnt_0", pkt_cnt_0, 12);
        chk("wrr_cnt_1", pkt_cnt_1, 4);

        // only input 1 active: borrowed grants leave pref on input 0
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send_pkt(1, 10 + p, 3);
            expect_pkt(1, 10 + p, 3, 3);
        end
        wait_drain("borrow", 300);
        chk("borrow_cnt_1", pkt_cnt_1, 4);
        chk("borrow_cnt_0", pkt_cnt_0, 0);
        send_pkt(0, 20, 2);
        send_pkt(1, 20, 2);
        expect_pkt(0, 20, 2, 2);
        expect_pkt(1, 20, 2, 2);
        wait_drain("borrow_pref", 100);
        chk("borrow_pref_cnt_1", pkt_cnt_1, 5);

        // output back-pressure during a 10-beat input-0 packet
        do_reset();
        w0 = 4'd1; w1 = 4'd1;
        base0 = fire0_cnt;
        t1_hi_seen = 1'b0;
        watch_t1 = 1'b1;
        stall_en = 1'b1;
        send_pkt(0, 30, 10);
        send_pkt(1, 30, 3);
        expect_pkt(0, 30, 10, 10);
        expect_pkt(1, 30, 3, 3);
        wait_fire(0, base0 + 10, "stall_pkt0");
        watch_t1 = 1'b0;
        chk("stall_tready_1_low", t1_hi_seen, 0);
        wait_drain("stall", 500);
        stall_en = 1'b0;
        chk("stall_cnt_0", pkt_cnt_0, 1);
        chk("stall_cnt_1", pkt_cnt_1, 1);

        // capture disable/enable at packet boundaries, with a concurrent input-0 packet
        do_reset();
        cap_en = 1'b1;
        base1 = fire1_cnt;
        send_pkt(1, 40, 6);
        send_pkt(1, 41, 5);
        send_pkt(1, 42, 4);
        send_pkt(1, 43, 3);
        expect_pkt(1, 40, 6, 6);
        wait_fire(1, base1 + 3, "drop_beat3");
        cap_en = 1'b0;
        send_pkt(0, 44, 4);
        expect_pkt(0, 44, 4, 4);
        expect_pkt(1, 43, 3, 3);
        wait_fire(1, base1 + 11, "drop_pkt_b");
        chk("drop_cnt_after_b", drop_cnt_1, 1);
        chk("drop_simul_cnt_0", pkt_cnt_0, 1);
        chk("drop_tready_1_high", s_tready_1, 1);
        wait_fire(1, base1 + 13, "drop_beat2_c");
        cap_en = 1'b1;
        wait_drain("drop", 300);
        chk("drop_cnt_final", drop_cnt_1, 2);
        chk("drop_fwd_cnt_1", pkt_cnt_1, 2);

        // reset in the middle of an input-0 packet
        base0 = fire0_cnt;
        send_pkt(0, 50, 6);
        expect_pkt(0, 50, 6, 2);
        wait_fire(0, base0 + 2, "mid_rst_beat2");
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("mid_rst_m_tvalid", m_tvalid, 0);
        chk("mid_rst_tready_0", s_tready_0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_cnt_1", pkt_cnt_1, 0);
        chk("mid_rst_drop_cnt", drop_cnt_1, 0);
        chk("mid_rst_idle_valid", m_tvalid, 0);
        send_pkt(1, 51, 3);
        expect_pkt(1, 51, 3, 3);
        for (k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m_tvalid) break;
        end
        checks++;
        if (k > 1) begin
            errors++;
            $display("FAIL post_rst_grant: first output after %0d cycles, required at most 1", k);
        end
        step(1);
        wait_drain("post_rst", 100);
        chk("post_rst_cnt_1", pkt_cnt_1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
